// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller: start validation, bit timing, parity, stop, error flags
module uart_rx_frame_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW   = 4;
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY_MODE != 0);
    localparam logic          ODD_PAR   = (PARITY_MODE == 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START_CHK = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_LOAD      = 3'd5;

    logic [2:0]           state;
    logic [TW-1:0]        timer;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 line_prev;
    logic                 par_bit;
    logic                 stop_fault;
    logic                 parity_bad;
    logic                 bit_tick;

    assign busy       = (state != S_IDLE);
    assign bit_tick   = (timer == BIT_LAST);
    assign parity_bad = HAS_PAR && ((^shift_reg ^ par_bit) != ODD_PAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            rx_data       <= '0;
            line_prev     <= 1'b1;
            par_bit       <= 1'b0;
            stop_fault    <= 1'b0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            line_prev <= serial_in;

            // A read only acknowledges data that is actually pending; LOAD below may override it
            if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (line_prev && !serial_in) begin
                        state <= S_START_CHK;
                        timer <= '0;
                    end
                end
                S_START_CHK: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (!serial_in) begin
                            state         <= S_DATA;
                            bit_cnt       <= '0;
                            stop_fault    <= 1'b0;
                            framing_error <= 1'b0;
                            parity_error  <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        timer     <= '0;
                        shift_reg <= {serial_in, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= HAS_PAR ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        timer   <= '0;
                        par_bit <= serial_in;
                        state   <= S_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        timer <= '0;
                        if (!serial_in) begin
                            stop_fault <= 1'b1;
                        end
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= S_LOAD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LOAD: begin
                    state         <= S_IDLE;
                    framing_error <= stop_fault;
                    parity_error  <= parity_bad;
                    // Good frame overwrites; a simultaneous read consumes the old word, so no overrun
                    if (!stop_fault && !parity_bad) begin
                        rx_data    <= shift_reg;
                        data_ready <= 1'b1;
                        if (data_ready && !data_read) begin
                            overrun_error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ser;
    logic [2:0] rd;
    logic [7:0] rx0;
    logic [7:0] rx1;
    logic [6:0] rx2;
    logic [2:0] dr_v;
    logic [2:0] fe_v;
    logic [2:0] pe_v;
    logic [2:0] ov_v;
    logic [2:0] busy_v;

    int checks = 0;
    int errors = 0;
    int rise;
    int bfirst;
    int blast;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(10), .PARITY_MODE(0), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst(rst), .serial_in(ser[0]), .data_read(rd[0]), .rx_data(rx0),
        .data_ready(dr_v[0]), .framing_error(fe_v[0]), .parity_error(pe_v[0]),
        .overrun_error(ov_v[0]), .busy(busy_v[0])
    );

    uart_rx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(10), .PARITY_MODE(1), .STOP_BITS(1)) u_par (
        .clk(clk), .rst(rst), .serial_in(ser[1]), .data_read(rd[1]), .rx_data(rx1),
        .data_ready(dr_v[1]), .framing_error(fe_v[1]), .parity_error(pe_v[1]),
        .overrun_error(ov_v[1]), .busy(busy_v[1])
    );

    uart_rx_frame_ctrl #(.DATA_BITS(7), .CLKS_PER_BIT(10), .PARITY_MODE(0), .STOP_BITS(2)) u_7b2 (
        .clk(clk), .rst(rst), .serial_in(ser[2]), .data_read(rd[2]), .rx_data(rx2),
        .data_ready(dr_v[2]), .framing_error(fe_v[2]), .parity_error(pe_v[2]),
        .overrun_error(ov_v[2]), .busy(busy_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_pulse(input int w);
        rd[w] = 1'b1;
        @(posedge clk);
        #1;
        rd[w] = 1'b0;
    endtask

    // Bit 0 of frame is the start bit; each bit held for 10 clocks. Cycle c = posedges since line fell.
    task automatic send(input int w, input logic [15:0] frame, input int nbits, input int rd_cycle,
                        input int abort_at, output int r, output int bf, output int bl);
        logic prev;
        r    = -1;
        bf   = -1;
        bl   = -1;
        prev = dr_v[w];
        for (int c = 0; c < nbits * 10; c++) begin
            if (c == abort_at) begin
                return;
            end
            ser[w] = frame[c / 10];
            rd[w]  = (c == rd_cycle);
            @(posedge clk);
            #1;
            if (busy_v[w] && bf < 0) bf = c + 1;
            if (busy_v[w]) bl = c + 1;
            if (dr_v[w] && !prev && r < 0) r = c + 1;
            prev = dr_v[w];
        end
        ser[w] = 1'b1;
        rd[w]  = 1'b0;
    endtask

    initial begin
        ser = 3'b111;
        rd  = 3'b000;
        rst = 1'b1;
        #1;
        check("reset_rx", {24'd0, rx0}, 32'h0);
        check("reset_flags", {28'd0, dr_v[0], fe_v[0], pe_v[0], ov_v[0]}, 32'h0);
        check("reset_busy", {31'd0, busy_v[0]}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // 1: 0xA5 8N1, latency and busy window
        send(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, -1, -1, rise, bfirst, blast);
        check("t1_rx", {24'd0, rx0}, 32'hA5);
        check("t1_rise", rise, 97);
        check("t1_busy_first", bfirst, 1);
        check("t1_busy_last", blast, 96);
        check("t1_flags", {29'd0, fe_v[0], pe_v[0], ov_v[0]}, 32'h0);
        idle(4);

        // 2: three-cycle glitch rejected by start check
        ser[0] = 1'b0;
        idle(3);
        ser[0] = 1'b1;
        idle(2);
        check("t2_busy_e5", {31'd0, busy_v[0]}, 32'h1);
        idle(1);
        check("t2_busy_e6", {31'd0, busy_v[0]}, 32'h0);
        check("t2_state", {23'd0, rx0, dr_v[0]}, {23'd0, 8'hA5, 1'b1});
        check("t2_flags", {29'd0, fe_v[0], pe_v[0], ov_v[0]}, 32'h0);
        idle(4);

        // 3: framing error, then good frame clears it
        read_pulse(0);
        check("t3_read_clr", {31'd0, dr_v[0]}, 32'h0);
        send(0, {6'd0, 1'b0, 8'h3C, 1'b0}, 10, -1, -1, rise, bfirst, blast);
        idle(2);
        check("t3_fe", {31'd0, fe_v[0]}, 32'h1);
        check("t3_dr", {31'd0, dr_v[0]}, 32'h0);
        check("t3_rx_kept", {24'd0, rx0}, 32'hA5);
        idle(4);
        send(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10, -1, -1, rise, bfirst, blast);
        check("t3_fe_clr", {31'd0, fe_v[0]}, 32'h0);
        check("t3_rx11", {23'd0, rx0, dr_v[0]}, {23'd0, 8'h11, 1'b1});
        idle(4);

        // 4: even parity
        send(1, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, -1, rise, bfirst, blast);
        check("t4_pe", {31'd0, pe_v[1]}, 32'h1);
        check("t4_noload", {23'd0, rx1, dr_v[1]}, 32'h0);
        idle(4);
        send(1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, -1, rise, bfirst, blast);
        check("t4_pe_clr", {31'd0, pe_v[1]}, 32'h0);
        check("t4_load", {23'd0, rx1, dr_v[1]}, {23'd0, 8'h07, 1'b1});
        idle(4);

        // 5: overrun, then same-cycle read at LOAD
        read_pulse(0);
        send(0, {6'd0, 1'b1, 8'h12, 1'b0}, 10, -1, -1, rise, bfirst, blast);
        check("t5_first_ov", {31'd0, ov_v[0]}, 32'h0);
        idle(4);
        send(0, {6'd0, 1'b1, 8'h34, 1'b0}, 10, -1, -1, rise, bfirst, blast);
        check("t5_ov", {31'd0, ov_v[0]}, 32'h1);
        check("t5_rx", {24'd0, rx0}, 32'h34);
        read_pulse(0);
        check("t5_read_clr", {30'd0, dr_v[0], ov_v[0]}, 32'h0);
        idle(4);
        send(0, {6'd0, 1'b1, 8'h12, 1'b0}, 10, -1, -1, rise, bfirst, blast);
        idle(4);
        send(0, {6'd0, 1'b1, 8'h34, 1'b0}, 10, 96, -1, rise, bfirst, blast);
        check("t5_rd_load", {22'd0, rx0, dr_v[0], ov_v[0]}, {22'd0, 8'h34, 1'b1, 1'b0});
        idle(4);

        // 6: reset mid data bit 4, then full frames
        send(0, {6'd0, 1'b1, 8'hF0, 1'b0}, 10, -1, 55, rise, bfirst, blast);
        check("t6_busy_pre", {31'd0, busy_v[0]}, 32'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_out", {19'd0, rx0, dr_v[0], fe_v[0], pe_v[0], ov_v[0], busy_v[0]}, 32'h0);
        ser[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        send(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10, -1, -1, rise, bfirst, blast);
        check("t6_rx5a", {23'd0, rx0, dr_v[0]}, {23'd0, 8'h5A, 1'b1});
        check("t6_rise5a", rise, 97);
        send(2, {6'd0, 2'b11, 7'h55, 1'b0}, 10, -1, -1, rise, bfirst, blast);
        check("t6_rx55", {24'd0, rx2, dr_v[2]}, {24'd0, 7'h55, 1'b1});
        check("t6_rise55", rise, 97);
        check("t6_fe7", {31'd0, fe_v[2]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
